frame_cropper: RTL and testbench
================================

Name: frame_cropper

Overview:
- Removes TOP/BOTTOM lines and LEFT/RIGHT pixels from an AXI4-Stream video frame. This is the inverse of the border-extending pipeline stage.
- Used after processing kernels that were fed an extended frame, to return the stream to the native resolution.
- Sits between a kernel output and downstream sinks in the img_proc_lib pipeline.
- Regenerates tuser (start of frame) and tlast (end of line) for the cropped geometry.

Parameters:
- TOP, 1: lines dropped at frame start.
- BOTTOM, 1: lines dropped at frame end.
- LEFT, 1: pixels dropped at line start.
- RIGHT, 1: pixels dropped at line end.
- FRAME_RES_X, 1920: input line length in pixels.
- FRAME_RES_Y, 1080: input lines per frame.
- PX_WIDTH, 10: pixel width. TDATA_WIDTH = PX_WIDTH rounded up to a multiple of 8.

Ports:
- clk_i, input, 1: clock. Single clock domain.
- rst_i, input, 1: reset, asynchronous, active-high.
- video_i, axi4_stream_if.slave, TDATA_WIDTH: input frame. tuser marks the first pixel of a frame; tlast marks the last pixel of a line.
- video_o, axi4_stream_if.master, TDATA_WIDTH: cropped frame of (FRAME_RES_X-LEFT-RIGHT) x (FRAME_RES_Y-TOP-BOTTOM) pixels.

Behaviour:
- Counters:
  - x_cnt and y_cnt, each $clog2(RES+1) bits.
  - A beat is "kept" when TOP <= y_cnt < FRAME_RES_Y-BOTTOM and LEFT <= x_cnt < FRAME_RES_X-RIGHT.
- States:
  - IDLE_S: discard beats until tuser. A beat with tuser sets x=0, y=0 and moves to ACTIVE_S; that beat itself is evaluated for keep.
  - ACTIVE_S: each accepted beat increments x_cnt. tlast sets x_cnt=0 and y_cnt+1. tlast when y_cnt == FRAME_RES_Y-BOTTOM-1 moves to IDLE_S (bottom lines are dropped there).
  - A tuser beat in ACTIVE_S restarts the counters (treated as a new frame).
- Output stage:
  - Single registered stage; latency from video_i handshake to video_o.tvalid is 1 cycle.
  - video_i.tready = 1 for dropped beats. For kept beats, video_i.tready = !o_valid || video_o.tready.
  - No bubbles under continuous flow.
- Output sideband:
  - video_o.tuser = 1 on the kept beat with x=LEFT, y=TOP; 0 otherwise.
  - video_o.tlast = 1 on a kept beat with x == FRAME_RES_X-RIGHT-1.
  - tdata, tkeep, tstrb, tid and tdest are forwarded unchanged.
- Short line (tlast at x < FRAME_RES_X-1):
  - If that beat is kept, it is output with tlast=1, producing a short output line.
  - If it is not kept, nothing is emitted for that line.
  - Counters advance normally either way.
- Long line (x reaches FRAME_RES_X without tlast): beats are dropped until tlast. x_cnt saturates at FRAME_RES_X.
- Zero parameters: with all four crop parameters at 0, the output is bit-exact with the input, plus 1 cycle of latency.
- Simultaneous tuser and tlast on one beat: tuser restart applies first, then tlast advances y to 1.
- Reset:
  - Asynchronous; o_valid=0, all video_o fields 0, state=IDLE_S, counters=0.
  - A frame cut by reset is lost. The next tuser starts a clean frame.
- Parameter check: elaboration fails if LEFT+RIGHT >= FRAME_RES_X or TOP+BOTTOM >= FRAME_RES_Y.

Optional Feature:
- Macro: FRAME_CROPPER_ERR_CNT_EN.
- When defined:
  - Adds output port err_cnt_o [15:0], a saturating count of short lines, long lines and tuser in ACTIVE_S.
  - Each event increments by 1. The count holds at 0xFFFF and resets to 0.
- When undefined: the port is absent and the datapath behaviour is identical.

Test Plan:
All tests use FRAME_RES_X=8, FRAME_RES_Y=6, TOP=1, BOTTOM=1, LEFT=2, RIGHT=1, with tdata = y*16+x.
- Nominal frame, video_o.tready=1 -> 20 beats out. First beat 0x12 with tuser=1; tlast on 0x16, 0x26, 0x36, 0x46; last beat 0x46; then idle.
- Same frame with random 50% video_o.tready and 30% video_i.tvalid gaps -> identical 20-beat sequence, no loss or duplicates.
- All crop parameters 0, 2 back-to-back frames -> output equals input beat-for-beat; tuser on 0x00; tlast on every x=7.
- Line y=2 ends with tlast at x=4 -> that line outputs 0x22, 0x23, 0x24(tlast=1); remaining lines are unaffected; err_cnt_o=1 when the macro is enabled.
- tuser arrives at y=3, x=0 mid-frame -> cropping restarts; next output 0x12-equivalent (x=2, y=1 of the new frame) carries tuser=1; err_cnt_o increments.
- rst_i pulsed during line y=2 -> video_o.tvalid drops to 0 immediately; the next full frame produces the nominal 20-beat sequence.

Source files
------------

// File: rtl/frame_cropper_if.sv
// AXI4-Stream video interface shared by the img_proc_lib pipeline stages.
// tuser marks start of frame, tlast marks end of line.
interface axi4_stream_if #(
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned ID_WIDTH   = 1,
    parameter int unsigned DEST_WIDTH = 1
);
    logic                      tvalid;
    logic                      tready;
    logic [DATA_WIDTH-1:0]     tdata;
    logic [DATA_WIDTH/8-1:0]   tkeep;
    logic [DATA_WIDTH/8-1:0]   tstrb;
    logic                      tlast;
    logic                      tuser;
    logic [ID_WIDTH-1:0]       tid;
    logic [DEST_WIDTH-1:0]     tdest;

    modport master (
        output tvalid, tdata, tkeep, tstrb, tlast, tuser, tid, tdest,
        input  tready
    );

    modport slave (
        input  tvalid, tdata, tkeep, tstrb, tlast, tuser, tid, tdest,
        output tready
    );
endinterface

// File: rtl/frame_cropper.sv
// Crops TOP/BOTTOM lines and LEFT/RIGHT pixels from an AXI4-Stream video frame.
// Define FRAME_CROPPER_ERR_CNT_EN to add err_cnt_o (short/long line and restart count).
module frame_cropper #(
    parameter int unsigned TOP         = 1,
    parameter int unsigned BOTTOM      = 1,
    parameter int unsigned LEFT        = 1,
    parameter int unsigned RIGHT       = 1,
    parameter int unsigned FRAME_RES_X = 1920,
    parameter int unsigned FRAME_RES_Y = 1080,
    parameter int unsigned PX_WIDTH    = 10,
    parameter int unsigned ID_WIDTH    = 1,
    parameter int unsigned DEST_WIDTH  = 1
) (
    input  logic         clk_i,
    input  logic         rst_i,
    axi4_stream_if.slave  video_i,
    axi4_stream_if.master video_o
`ifdef FRAME_CROPPER_ERR_CNT_EN
    ,
    output logic [15:0]  err_cnt_o
`endif
);

    localparam int unsigned TDATA_WIDTH = ((PX_WIDTH + 7) / 8) * 8;
    localparam int unsigned KEEP_WIDTH  = TDATA_WIDTH / 8;
    localparam int unsigned XW          = $clog2(FRAME_RES_X + 1);
    localparam int unsigned YW          = $clog2(FRAME_RES_Y + 1);

    localparam logic [XW-1:0] X_LO       = XW'(LEFT);
    localparam logic [XW-1:0] X_HI       = XW'(FRAME_RES_X - RIGHT);
    localparam logic [XW-1:0] X_LAST_OUT = XW'(FRAME_RES_X - RIGHT - 1);
    localparam logic [XW-1:0] X_END      = XW'(FRAME_RES_X - 1);
    localparam logic [XW-1:0] X_MAX      = XW'(FRAME_RES_X);
    localparam logic [YW-1:0] Y_LO       = YW'(TOP);
    localparam logic [YW-1:0] Y_HI       = YW'(FRAME_RES_Y - BOTTOM);
    localparam logic [YW-1:0] Y_LAST     = YW'(FRAME_RES_Y - BOTTOM - 1);

    if (LEFT + RIGHT >= FRAME_RES_X) begin : g_bad_x
        $error("frame_cropper: LEFT+RIGHT must be below FRAME_RES_X");
    end
    if (TOP + BOTTOM >= FRAME_RES_Y) begin : g_bad_y
        $error("frame_cropper: TOP+BOTTOM must be below FRAME_RES_Y");
    end

    typedef enum logic {IDLE_S, ACTIVE_S} state_t;

    state_t                  state_q, state_d;
    logic [XW-1:0]           x_q, x_d, x_eff;
    logic [YW-1:0]           y_q, y_d, y_eff;
    logic                    in_frame, keep, can_load, in_hs, load;
    logic                    out_user, out_last;

    logic                    o_valid_q;
    logic [TDATA_WIDTH-1:0]  o_data_q;
    logic [KEEP_WIDTH-1:0]   o_keep_q;
    logic [KEEP_WIDTH-1:0]   o_strb_q;
    logic                    o_last_q;
    logic                    o_user_q;
    logic [ID_WIDTH-1:0]     o_id_q;
    logic [DEST_WIDTH-1:0]   o_dest_q;

    // A tuser beat restarts the frame before it is evaluated, in either state.
    always_comb begin
        in_frame = video_i.tuser || (state_q == ACTIVE_S);
        x_eff    = video_i.tuser ? '0 : x_q;
        y_eff    = video_i.tuser ? '0 : y_q;
        keep     = in_frame && (y_eff >= Y_LO) && (y_eff < Y_HI) &&
                   (x_eff >= X_LO) && (x_eff < X_HI);
        out_user = (x_eff == X_LO) && (y_eff == Y_LO);
        out_last = video_i.tlast || (x_eff == X_LAST_OUT);

        can_load       = !o_valid_q || video_o.tready;
        video_i.tready = !keep || can_load;
        in_hs          = video_i.tvalid && video_i.tready;
        load           = in_hs && keep;

        state_d = state_q;
        x_d     = x_q;
        y_d     = y_q;
        if (in_hs && in_frame) begin
            if (video_i.tlast) begin
                x_d     = '0;
                y_d     = y_eff + YW'(1);
                state_d = (y_eff == Y_LAST) ? IDLE_S : ACTIVE_S;
            end else begin
                x_d     = (x_eff == X_MAX) ? X_MAX : x_eff + XW'(1);
                y_d     = y_eff;
                state_d = ACTIVE_S;
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q   <= IDLE_S;
            x_q       <= '0;
            y_q       <= '0;
            o_valid_q <= 1'b0;
            o_data_q  <= '0;
            o_keep_q  <= '0;
            o_strb_q  <= '0;
            o_last_q  <= 1'b0;
            o_user_q  <= 1'b0;
            o_id_q    <= '0;
            o_dest_q  <= '0;
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            y_q     <= y_d;
            if (load) begin
                o_valid_q <= 1'b1;
                o_data_q  <= video_i.tdata;
                o_keep_q  <= video_i.tkeep;
                o_strb_q  <= video_i.tstrb;
                o_last_q  <= out_last;
                o_user_q  <= out_user;
                o_id_q    <= video_i.tid;
                o_dest_q  <= video_i.tdest;
            end else if (video_o.tready) begin
                o_valid_q <= 1'b0;
            end
        end
    end

    assign video_o.tvalid = o_valid_q;
    assign video_o.tdata  = o_data_q;
    assign video_o.tkeep  = o_keep_q;
    assign video_o.tstrb  = o_strb_q;
    assign video_o.tlast  = o_last_q;
    assign video_o.tuser  = o_user_q;
    assign video_o.tid    = o_id_q;
    assign video_o.tdest  = o_dest_q;

`ifdef FRAME_CROPPER_ERR_CNT_EN
    logic [1:0]  err_inc;
    logic [16:0] err_sum;
    logic [15:0] err_cnt_q;

    // A restart beat can also be a short line, so up to two events per beat.
    always_comb begin
        err_inc = '0;
        if (in_hs && in_frame) begin
            err_inc = {1'b0, (state_q == ACTIVE_S) && video_i.tuser} +
                      {1'b0, video_i.tlast && (x_eff < X_END)} +
                      {1'b0, !video_i.tlast && (x_eff == X_END)};
        end
        err_sum = {1'b0, err_cnt_q} + {15'd0, err_inc};
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            err_cnt_q <= '0;
        end else begin
            err_cnt_q <= err_sum[16] ? 16'hFFFF : err_sum[15:0];
        end
    end

    assign err_cnt_o = err_cnt_q;
`endif

endmodule

// File: tb/tb_frame_cropper.sv
// Directed table-driven bench for frame_cropper on an 8x6 frame with tdata = y*16+x.
// A second instance with all crop parameters at 0 checks pass-through.
module tb_frame_cropper;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    axi4_stream_if #(.DATA_WIDTH(8)) a_in ();
    axi4_stream_if #(.DATA_WIDTH(8)) a_out ();
    axi4_stream_if #(.DATA_WIDTH(8)) b_in ();
    axi4_stream_if #(.DATA_WIDTH(8)) b_out ();

`ifdef FRAME_CROPPER_ERR_CNT_EN
    logic [15:0] err_a, err_b;
`endif

    frame_cropper #(
        .TOP(1), .BOTTOM(1), .LEFT(2), .RIGHT(1),
        .FRAME_RES_X(8), .FRAME_RES_Y(6), .PX_WIDTH(8)
    ) u_dut (
        .clk_i   (clk),
        .rst_i   (rst),
        .video_i (a_in),
        .video_o (a_out)
`ifdef FRAME_CROPPER_ERR_CNT_EN
        ,
        .err_cnt_o (err_a)
`endif
    );

    frame_cropper #(
        .TOP(0), .BOTTOM(0), .LEFT(0), .RIGHT(0),
        .FRAME_RES_X(8), .FRAME_RES_Y(6), .PX_WIDTH(8)
    ) u_dut_zero (
        .clk_i   (clk),
        .rst_i   (rst),
        .video_i (b_in),
        .video_o (b_out)
`ifdef FRAME_CROPPER_ERR_CNT_EN
        ,
        .err_cnt_o (err_b)
`endif
    );

    typedef struct packed {
        logic [7:0] data;
        logic       user;
        logic       last;
    } beat_t;

    typedef struct {
        string name;
        bit    gaps;
        bit    rnd_rdy;
        int    short_y;
        int    short_x;
        int    stop_y;
        int    stop_x;
        int    beats;
        int    err_delta;
    } vec_t;

    int    n_cmp = 0;
    int    n_bad = 0;
    bit    gaps = 0;
    bit    rnd_rdy = 0;
    beat_t exp_a[$], exp_b[$], cap_a[$], cap_b[$];
    vec_t  vecs[4];

    task automatic check(input string name, input int act, input int req);
        n_cmp++;
        if (act != req) begin
            n_bad++;
            $display("FAIL %s: got 'h%0h, required 'h%0h", name, act, req);
        end
    endtask

    always @(negedge clk) a_out.tready = rnd_rdy ? 1'($urandom_range(0, 1)) : 1'b1;

    // Sample just before the rising edge so handshakes are seen as the DUT sees them.
    always begin
        @(negedge clk);
        #4;
        if (!rst) begin
            if (a_out.tvalid && a_out.tready)
                cap_a.push_back({a_out.tdata, a_out.tuser, a_out.tlast});
            if (b_out.tvalid && b_out.tready)
                cap_b.push_back({b_out.tdata, b_out.tuser, b_out.tlast});
        end
    end

    task automatic send_beat(input int dut, input logic [7:0] d, input logic u, input logic l);
        bit acc;
        int n;
        if (gaps) while ($urandom_range(0, 9) < 3) @(negedge clk);
        if (dut == 0) begin
            a_in.tvalid = 1'b1; a_in.tdata = d; a_in.tuser = u; a_in.tlast = l;
        end else begin
            b_in.tvalid = 1'b1; b_in.tdata = d; b_in.tuser = u; b_in.tlast = l;
        end
        acc = 1'b0;
        n = 0;
        while (!acc && n < 200) begin
            #4;
            acc = (dut == 0) ? a_in.tready : b_in.tready;
            @(negedge clk);
            n++;
        end
        if (!acc) check("input handshake timeout", 0, 1);
        a_in.tvalid = 1'b0;
        b_in.tvalid = 1'b0;
    endtask

    // Sends one 8x6 frame (optionally short line / early stop) and records expected output.
    task automatic gen_frame(input int dut, input int stop_y, input int stop_x,
                             input int short_y, input int short_x);
        int t, b, lf, r;
        logic l;
        beat_t e;
        if (dut == 0) begin t = 1; b = 1; lf = 2; r = 1; end
        else begin t = 0; b = 0; lf = 0; r = 0; end
        for (int y = 0; y < 6; y++) begin
            for (int x = 0; x < 8; x++) begin
                if (y == stop_y && x == stop_x) return;
                l = (x == 7) || (y == short_y && x == short_x);
                if (y >= t && y < 6 - b && x >= lf && x < 8 - r) begin
                    e.data = 8'(y * 16 + x);
                    e.user = (x == lf && y == t);
                    e.last = l || (x == 7 - r);
                    if (dut == 0) exp_a.push_back(e); else exp_b.push_back(e);
                end
                send_beat(dut, 8'(y * 16 + x), (x == 0 && y == 0), l);
                if (l) break;
            end
        end
    endtask

    task automatic drain();
        rnd_rdy = 0;
        repeat (10) @(negedge clk);
    endtask

    task automatic compare_q(input string name, input int dut, input int hand_cnt);
        beat_t e[$], c[$];
        int n;
        if (dut == 0) begin e = exp_a; c = cap_a; end else begin e = exp_b; c = cap_b; end
        check({name, " beat count"}, c.size(), hand_cnt);
        check({name, " model count"}, c.size(), e.size());
        n = (c.size() < e.size()) ? c.size() : e.size();
        for (int i = 0; i < n; i++)
            check($sformatf("%s beat %0d {data,user,last}", name, i), int'(c[i]), int'(e[i]));
        exp_a.delete(); cap_a.delete(); exp_b.delete(); cap_b.delete();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout, required finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{"nominal",      1'b0, 1'b0, -1, -1, -1, -1, 20, 0};
        vecs[1] = '{"backpressure", 1'b1, 1'b1, -1, -1, -1, -1, 20, 0};
        vecs[2] = '{"short_line",   1'b0, 1'b0,  2,  4, -1, -1, 18, 1};
        vecs[3] = '{"mid_tuser",    1'b0, 1'b0, -1, -1,  3,  0, 30, 1};

        a_in.tvalid = 0; a_in.tdata = 0; a_in.tuser = 0; a_in.tlast = 0;
        a_in.tkeep = 1; a_in.tstrb = 1; a_in.tid = 0; a_in.tdest = 0;
        b_in.tvalid = 0; b_in.tdata = 0; b_in.tuser = 0; b_in.tlast = 0;
        b_in.tkeep = 1; b_in.tstrb = 1; b_in.tid = 0; b_in.tdest = 0;
        b_out.tready = 1'b1;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check("reset tvalid", int'(a_out.tvalid), 0);
        check("reset tdata", int'(a_out.tdata), 0);
        check("reset tuser/tlast", int'({a_out.tuser, a_out.tlast}), 0);
`ifdef FRAME_CROPPER_ERR_CNT_EN
        check("reset err_cnt", int'(err_a), 0);
`endif
        rst = 1'b0;
        @(negedge clk);

        // Beats before any tuser are discarded.
        send_beat(0, 8'h33, 1'b0, 1'b0);
        send_beat(0, 8'h34, 1'b0, 1'b1);
        send_beat(0, 8'h35, 1'b0, 1'b0);
        drain();
        check("idle discard beat count", cap_a.size(), 0);
        cap_a.delete();

        for (int i = 0; i < 4; i++) begin
            int e0;
            e0 = 0;
`ifdef FRAME_CROPPER_ERR_CNT_EN
            e0 = int'(err_a);
`endif
            gaps = vecs[i].gaps;
            rnd_rdy = vecs[i].rnd_rdy;
            if (vecs[i].stop_y >= 0) gen_frame(0, vecs[i].stop_y, vecs[i].stop_x, -1, -1);
            gen_frame(0, -1, -1, vecs[i].short_y, vecs[i].short_x);
            gaps = 0;
            drain();
            if (i == 0 && cap_a.size() == 20) begin
                check("nominal first beat", int'(cap_a[0]), int'({8'h12, 1'b1, 1'b0}));
                check("nominal last beat", int'(cap_a[19]), int'({8'h46, 1'b0, 1'b1}));
                check("nominal 0x16 tlast", int'(cap_a[4]), int'({8'h16, 1'b0, 1'b1}));
            end
            if (i == 2 && cap_a.size() == 18)
                check("short line end", int'(cap_a[7]), int'({8'h24, 1'b0, 1'b1}));
            if (i == 3 && cap_a.size() == 30)
                check("restart tuser", int'(cap_a[10]), int'({8'h12, 1'b1, 1'b0}));
`ifdef FRAME_CROPPER_ERR_CNT_EN
            check({vecs[i].name, " err_cnt delta"}, int'(err_a) - e0, vecs[i].err_delta);
`endif
            compare_q(vecs[i].name, 0, vecs[i].beats);
        end

        // Zero crop: two back-to-back frames pass unchanged.
        gen_frame(1, -1, -1, -1, -1);
        gen_frame(1, -1, -1, -1, -1);
        drain();
        if (cap_b.size() == 96) begin
            check("zero first beat", int'(cap_b[0]), int'({8'h00, 1'b1, 1'b0}));
            check("zero line end", int'(cap_b[7]), int'({8'h07, 1'b0, 1'b1}));
        end
        compare_q("zero_crop", 1, 96);

        // Reset during line y=2 while an output beat is pending.
        gen_frame(0, 2, 4, -1, -1);
        check("pre-reset tvalid", int'(a_out.tvalid), 1);
        #1 rst = 1'b1;
        #1;
        check("reset drops tvalid", int'(a_out.tvalid), 0);
`ifdef FRAME_CROPPER_ERR_CNT_EN
        check("reset clears err_cnt", int'(err_a), 0);
`endif
        @(negedge clk);
        rst = 1'b0;
        exp_a.delete();
        cap_a.delete();
        @(negedge clk);
        gen_frame(0, -1, -1, -1, -1);
        drain();
        compare_q("after_reset", 0, 20);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
